afifo_rsched: RTL and testbench

Read-side burst scheduler for the asynchronous FIFO. It shares the FIFO's single read port among N consumers in `rclk`. It admits one burst at a time by round-robin and drives the read-increment strobe. It tags each popped word with the owning requester and sequences soft flushes through the read-domain soft reset.

---
 rtl/afifo_pkg.sv | 14 +
 rtl/rr_arb.sv | 29 ++
 rtl/afifo_rsched.sv | 176 +++++++++++++++++
 tb/tb_afifo_rsched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared types and constants for the asynchronous FIFO read/write schedulers.
package afifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP,
        FLUSH
    } afifo_rsched_st_e;

    // Settle time after a burst so the registered almost-empty flag catches up.
    localparam int unsigned AFIFO_GAP_CYC = 2;

endpackage

// File: rtl/rr_arb.sv
// N-way one-hot round-robin arbiter; priority starts at the index after ptr_i.
module rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] id_o
);

    // Scan from ptr_i+1 around the ring; first requester found wins.
    always_comb begin
        logic found;
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/afifo_rsched.sv
// Read-side burst scheduler: round-robin burst admission onto the FIFO read port,
// pop tagging, and soft-flush sequencing through the read-domain soft reset.
module afifo_rsched
    import afifo_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned LW = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            rclk,
    input  logic            rrst_n,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] blen,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [N-1:0]    abort,
    input  logic            rempty,
    input  logic            arempty,
    output logic            rinc,
    output logic            rsrst,
    output logic            pop_vld,
    output logic [IW-1:0]   pop_id,
    output logic            pop_last,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            busy
);

    afifo_rsched_st_e st_q, st_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [LW-1:0] blen_q, blen_d;
    logic [LW:0]   cnt_q, cnt_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [1:0]    gap_q, gap_d;
    logic          pend_q, pend_d;
    logic          pop_vld_q, pop_vld_d;
    logic [IW-1:0] pop_id_q, pop_id_d;
    logic          pop_last_q, pop_last_d;
    logic [N-1:0]  done_q, done_d;
    logic [N-1:0]  abort_q, abort_d;
    logic          fdone_q, fdone_d;

    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_id;
    logic          pop;
    logic          last_beat;

    rr_arb #(
        .N (N),
        .IW(IW)
    ) u_arb (
        .req_i(req),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .id_o (arb_id)
    );

    assign rinc      = (st_q == BURST) & ~rempty;
    assign pop       = rinc;
    assign last_beat = (cnt_q == {1'b0, blen_q});

    // Next-state logic for the scheduler FSM and its delivery pipeline.
    always_comb begin
        st_d       = st_q;
        gnt_d      = gnt_q;
        blen_d     = blen_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        gap_d      = gap_q;
        pend_d     = pend_q;
        pop_vld_d  = pop;
        pop_id_d   = id_q;
        pop_last_d = pop & last_beat;
        done_d     = '0;
        abort_d    = '0;
        fdone_d    = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (flush_req) begin
                    st_d = FLUSH;
                end else if (|req && !arempty) begin
                    st_d   = BURST;
                    gnt_d  = arb_gnt;
                    id_d   = arb_id;
                    ptr_d  = arb_id;
                    blen_d = blen[arb_id*LW +: LW];
                    cnt_d  = '0;
                end
            end
            BURST: begin
                if (flush_req) begin
                    // The pop made this cycle still delivers, but the owner sees abort.
                    st_d    = FLUSH;
                    gnt_d   = '0;
                    abort_d = gnt_q;
                end else if (pop) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        st_d   = GAP;
                        gap_d  = '0;
                        gnt_d  = '0;
                        done_d = gnt_q;
                    end
                end
            end
            FLUSH: begin
                st_d    = GAP;
                gap_d   = '0;
                fdone_d = 1'b1;
                pend_d  = pend_q | flush_req;
            end
            GAP: begin
                if (gap_q == 2'(AFIFO_GAP_CYC - 1)) begin
                    if (pend_q || flush_req) begin
                        st_d   = FLUSH;
                        pend_d = 1'b0;
                    end else begin
                        st_d = IDLE;
                    end
                end else begin
                    gap_d  = gap_q + 1'b1;
                    pend_d = pend_q | flush_req;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            st_q       <= IDLE;
            gnt_q      <= '0;
            blen_q     <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            ptr_q      <= IW'(N - 1);
            gap_q      <= '0;
            pend_q     <= 1'b0;
            pop_vld_q  <= 1'b0;
            pop_id_q   <= '0;
            pop_last_q <= 1'b0;
            done_q     <= '0;
            abort_q    <= '0;
            fdone_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            gnt_q      <= gnt_d;
            blen_q     <= blen_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            pop_vld_q  <= pop_vld_d;
            pop_id_q   <= pop_id_d;
            pop_last_q <= pop_last_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            fdone_q    <= fdone_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign abort      = abort_q;
    assign rsrst      = (st_q == FLUSH);
    assign busy       = (st_q != IDLE);
    assign pop_vld    = pop_vld_q;
    assign pop_id     = pop_id_q;
    assign pop_last   = pop_last_q;
    assign flush_done = fdone_q;

endmodule

// File: tb/tb_afifo_rsched.sv
// Self-checking bench for afifo_rsched: vector table, directed corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_afifo_rsched;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int IW = 2;

    logic            rclk = 1'b0;
    logic            rrst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] blen = '0;
    logic [N-1:0]    gnt, done, abort;
    logic            rempty = 1'b0, arempty = 1'b0, flush_req = 1'b0;
    logic            rinc, rsrst, pop_vld, pop_last, flush_done, busy;
    logic [IW-1:0]   pop_id;

    always #5 rclk = ~rclk;

    afifo_rsched #(
        .N (N),
        .LW(LW)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .req       (req),
        .blen      (blen),
        .gnt       (gnt),
        .done      (done),
        .abort     (abort),
        .rempty    (rempty),
        .arempty   (arempty),
        .rinc      (rinc),
        .rsrst     (rsrst),
        .pop_vld   (pop_vld),
        .pop_id    (pop_id),
        .pop_last  (pop_last),
        .flush_req (flush_req),
        .flush_done(flush_done),
        .busy      (busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs_vec();
        return {12'd0, gnt, done, abort, rinc, rsrst, pop_vld, pop_id, pop_last, flush_done, busy};
    endfunction

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int rr_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0; req = '0; blen = '0; rempty = 1'b0; arempty = 1'b0; flush_req = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [N*LW-1:0] blen;
        logic [N-1:0]    gnt;
        int              id;
        int              len;
    } vec_t;

    vec_t tbl[5];
    logic [N-1:0] rr_exp[5];
    logic [N-1:0] g_arr[5];
    int t_arr[5];
    int ng, rinc_n, pop_n, bad_id, beats, stall_left, stall_i, pops, rinc_stall, vld_stall;
    int burst_cyc, early, rs_n, ab_n, dn_n, vld_n, fd_ok, fd_n, pulses;
    int lw, owner, exp_len, delivered, bursts, rinc_err, pop_err, w;
    logic [N-1:0] done_v, ab_v, gprev, gnt_fl, req_s;
    logic [N*LW-1:0] blen_s;
    logic last_v, done_seen, sent, ab_with_rs, rs_prev, rinc_fl, are_s;
    logic [7:0] rs_v, fd_v, bz_v;

    initial begin
        tbl[0] = '{4'b0010, 16'h0030, 4'b0010, 1, 4};
        tbl[1] = '{4'b1111, 16'h0000, 4'b0001, 0, 1};
        tbl[2] = '{4'b1100, 16'h0F00, 4'b0100, 2, 16};
        tbl[3] = '{4'b1000, 16'h5000, 4'b1000, 3, 6};
        tbl[4] = '{4'b0110, 16'h0A70, 4'b0010, 1, 8};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values.
        do_reset();
        #1;
        check("reset outputs", outs_vec(), 32'd0);

        // Vector table: one burst from reset per entry.
        foreach (tbl[v]) begin
            do_reset();
            req = tbl[v].req; blen = tbl[v].blen;
            @(negedge rclk); #1;
            check($sformatf("tbl%0d gnt latency", v), 32'(gnt), 32'(tbl[v].gnt));
            rinc_n = 0; pop_n = 0; bad_id = 0; done_v = '0; last_v = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (rinc) rinc_n++;
                if (pop_vld) begin
                    pop_n++;
                    if (int'(pop_id) != tbl[v].id) bad_id++;
                end
                if (done != '0) begin
                    done_v = done; last_v = pop_last;
                    break;
                end
                @(negedge rclk); #1;
            end
            req = '0;
            check($sformatf("tbl%0d rinc count", v), 32'(rinc_n), 32'(tbl[v].len));
            check($sformatf("tbl%0d pop count", v), 32'(pop_n), 32'(tbl[v].len));
            check($sformatf("tbl%0d pop_id errs", v), 32'(bad_id), 32'd0);
            check($sformatf("tbl%0d done", v), 32'(done_v), 32'(tbl[v].gnt));
            check($sformatf("tbl%0d pop_last", v), 32'(last_v), 32'd1);
            @(negedge rclk); #1;
            check($sformatf("tbl%0d gap2 busy", v), 32'(busy), 32'd1);
            @(negedge rclk); #1;
            check($sformatf("tbl%0d idle busy", v), 32'(busy), 32'd0);
        end

        // Round-robin order and spacing with all requesters active.
        do_reset();
        req = 4'b1111; blen = '0; gprev = '0; ng = 0;
        foreach (g_arr[i]) begin g_arr[i] = '0; t_arr[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            @(negedge rclk); #1;
            if (gnt != '0 && gprev == '0 && ng < 5) begin
                g_arr[ng] = gnt; t_arr[ng] = c; ng++;
            end
            gprev = gnt;
        end
        req = '0;
        for (int i = 0; i < 5; i++) check($sformatf("rr grant %0d", i), 32'(g_arr[i]), 32'(rr_exp[i]));
        for (int i = 1; i < 5; i++) check($sformatf("rr spacing %0d", i), 32'(t_arr[i] - t_arr[i-1]), 32'd4);

        // Underflow stall: 8-beat burst, rempty high 5 cycles after beat 3.
        do_reset();
        req = 4'b0001; blen = 16'h0007;
        beats = 0; stall_left = 5; stall_i = 0; pops = 0; rinc_stall = 0; vld_stall = 0;
        burst_cyc = 0; done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge rclk);
            rempty = (beats >= 3 && stall_left > 0);
            if (rempty) begin stall_left--; stall_i++; end
            #1;
            if (rinc) beats++;
            if (rempty && rinc) rinc_stall++;
            if (pop_vld) pops++;
            if (rempty && stall_i >= 2 && pop_vld) vld_stall++;
            if (gnt != '0) burst_cyc++;
            if (done[0]) begin done_seen = 1'b1; req = '0; end
        end
        rempty = 1'b0;
        check("stall rinc while empty", 32'(rinc_stall), 32'd0);
        check("stall pop_vld during stall", 32'(vld_stall), 32'd0);
        check("stall beats", 32'(beats), 32'd8);
        check("stall pops", 32'(pops), 32'd8);
        check("stall burst cycles", 32'(burst_cyc), 32'd13);
        check("stall done", 32'(done_seen), 32'd1);

        // Admission gate on arempty.
        do_reset();
        req = 4'b0001; blen = '0; arempty = 1'b1; early = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk); #1;
            if (gnt != '0) early++;
        end
        check("gate no early grant", 32'(early), 32'd0);
        @(negedge rclk); arempty = 1'b0; #1;
        @(negedge rclk); #1;
        check("gate grant after fall", 32'(gnt), 32'b0001);
        req = '0;
        repeat (4) @(negedge rclk);

        // Flush at beat 2 of an 8-beat burst for requester 2.
        do_reset();
        req = 4'b0100; blen = 16'h0700;
        beats = 0; sent = 1'b0; rs_n = 0; ab_n = 0; dn_n = 0; vld_n = 0; fd_ok = 0; fd_n = 0;
        ab_v = '0; ab_with_rs = 1'b0; rs_prev = 1'b0; gnt_fl = 4'hF; rinc_fl = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            flush_req = (beats == 1 && !sent);
            if (flush_req) sent = 1'b1;
            #1;
            if (rinc) beats++;
            if (rsrst) begin rs_n++; gnt_fl = gnt; rinc_fl = rinc; end
            if (abort != '0) begin ab_n++; ab_v = abort; ab_with_rs = rsrst; req = '0; end
            if (done != '0) dn_n++;
            if (pop_vld) vld_n++;
            if (flush_done) fd_n++;
            if (flush_done && rs_prev) fd_ok++;
            rs_prev = rsrst;
        end
        flush_req = 1'b0;
        check("flush rsrst count", 32'(rs_n), 32'd1);
        check("flush abort count", 32'(ab_n), 32'd1);
        check("flush abort value", 32'(ab_v), 32'b0100);
        check("flush abort in rsrst cycle", 32'(ab_with_rs), 32'd1);
        check("flush no done", 32'(dn_n), 32'd0);
        check("flush beats delivered", 32'(vld_n), 32'd2);
        check("flush popped beats", 32'(beats), 32'd2);
        check("flush gnt in FLUSH", 32'(gnt_fl), 32'd0);
        check("flush rinc in FLUSH", 32'(rinc_fl), 32'd0);
        check("flush_done count", 32'(fd_n), 32'd1);
        check("flush_done after rsrst", 32'(fd_ok), 32'd1);

        // Flush from IDLE, second flush during its GAP.
        do_reset();
        rs_v = '0; fd_v = '0; bz_v = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            flush_req = (c == 0 || c == 2);
            #1;
            rs_v[c] = rsrst; fd_v[c] = flush_done; bz_v[c] = busy;
        end
        flush_req = 1'b0;
        check("dflush rsrst pattern", 32'(rs_v), 32'b0001_0010);
        check("dflush flush_done pattern", 32'(fd_v), 32'b0010_0100);
        check("dflush busy pattern", 32'(bz_v), 32'b0111_1110);

        // Reset mid-burst.
        do_reset();
        req = 4'b0001; blen = 16'h000F;
        repeat (4) @(negedge rclk);
        #1;
        check("midrst busy before", 32'(busy), 32'd1);
        @(negedge rclk); rrst_n = 1'b0; req = '0;
        @(negedge rclk); #1;
        check("midrst outputs", outs_vec(), 32'd0);
        rrst_n = 1'b1; pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk); #1;
            if (done != '0 || abort != '0 || pop_vld || busy) pulses++;
        end
        check("midrst no pulses", 32'(pulses), 32'd0);

        // Randomized run against a transaction-level model.
        do_reset();
        lw = N - 1; owner = -1; exp_len = 0; delivered = 0; bursts = 0; rinc_err = 0;
        pop_err = 0; gprev = '0; req_s = '0; blen_s = '0; are_s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge rclk);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    blen[i*LW +: LW] = LW'($urandom_range(0, 15));
                end
            end
            rempty  = ($urandom_range(0, 3) == 0);
            arempty = ($urandom_range(0, 4) == 0);
            #1;
            if (rinc && rempty) rinc_err++;
            if (gnt != '0 && gprev == '0) begin
                w = rr_model(req_s, lw);
                check("rand grant", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
                check("rand admit arempty", 32'(are_s), 32'd0);
                if (w >= 0) begin
                    lw = w; owner = w; delivered = 0;
                    exp_len = int'(blen_s[w*LW +: LW]) + 1;
                end
            end
            if (pop_vld) begin
                delivered++;
                if (int'(pop_id) != owner) pop_err++;
                if (pop_last != (delivered == exp_len)) pop_err++;
                if (delivered == exp_len) begin
                    bursts++;
                    if (owner < 0 || done != (4'b0001 << owner)) pop_err++;
                end else if (done != '0) pop_err++;
            end else if (done != '0) pop_err++;
            if (abort != '0 || rsrst) pop_err++;
            for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
            req_s = req; blen_s = blen; are_s = arempty; gprev = gnt;
        end
        check("rand rinc into empty", 32'(rinc_err), 32'd0);
        check("rand delivery errors", 32'(pop_err), 32'd0);
        check("rand enough bursts", 32'(bursts > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
